wb_shared_bus_rr: RTL and testbench
===================================

Name: wb_shared_bus_rr

Overview:
- Parametrised Wishbone B4 classic shared-bus interconnect: N masters, M slaves, one bus.
- Round-robin arbitration with grant held for the whole cycle.
- Slave decode from per-slave base/mask parameters.
- Interconnect-generated error on unmapped addresses and on slave timeout.
- Sits between CPU/DMA masters and peripheral slaves; successor to the fixed two-master, priority-arbitrated intercon.

Parameters:
MASTERS, 2, number of master ports (1..8)
SLAVES, 4, number of slave ports (1..16)
DATA_WIDTH, 32, data bus width in bits (8, 16, 32, 64)
ADDR_WIDTH, 32, address bus width in bits
SELECT_WIDTH, DATA_WIDTH/8, byte-select width
SLAVE_BASE, {SLAVES{ADDR_WIDTH'0}}, concatenated per-slave base addresses; slave i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
SLAVE_MASK, {SLAVES{ADDR_WIDTH'0}}, concatenated per-slave decode masks, same packing
TIMEOUT, 255, cycles of stb without termination before interconnect error; 0 disables

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
m_adr_i  input  MASTERS*ADDR_WIDTH  master addresses, packed
m_dat_i  input  MASTERS*DATA_WIDTH  master write data, packed
m_sel_i  input  MASTERS*SELECT_WIDTH  master byte selects, packed
m_we_i  input  MASTERS  master write enables
m_stb_i  input  MASTERS  master strobes
m_cyc_i  input  MASTERS  master cycle requests
m_dat_o  output  DATA_WIDTH  read data, broadcast to all masters
m_ack_o  output  MASTERS  ack, granted master only
m_err_o  output  MASTERS  err, granted master only
m_rty_o  output  MASTERS  rty, granted master only
s_adr_o  output  ADDR_WIDTH  shared slave address
s_dat_o  output  DATA_WIDTH  shared slave write data
s_sel_o  output  SELECT_WIDTH  shared byte selects
s_we_o  output  1  shared write enable
s_cyc_o  output  SLAVES  per-slave cyc, decoded
s_stb_o  output  SLAVES  per-slave stb, decoded
s_dat_i  input  SLAVES*DATA_WIDTH  slave read data, packed
s_ack_i  input  SLAVES  slave acks
s_err_i  input  SLAVES  slave errors
s_rty_i  input  SLAVES  slave retries
grant_o  output  MASTERS  one-hot current grant, 0 when idle

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - State IDLE; grant_o=0; round-robin pointer=0; timeout counter=0; error-pending flag=0.
  - All m_ack_o/m_err_o/m_rty_o=0; all s_cyc_o/s_stb_o=0; m_dat_o=0.
  - rst mid-transfer drops the grant and all slave strobes on the next edge; no termination is delivered.
- FSM states: IDLE, BUSY.
  - IDLE: if any m_cyc_i, register one-hot grant to the first requester found scanning from pointer, wrapping (pointer, pointer+1, ..., MASTERS-1, 0, ...); go BUSY. One-cycle arbitration latency.
  - BUSY: grant held while granted m_cyc_i=1; other requests ignored.
  - BUSY, granted m_cyc_i=0: on that edge grant_o=0, pointer=(granted index+1) mod MASTERS, go IDLE. Minimum one idle cycle between grants.
- Muxing in BUSY is combinational from the granted master: s_adr_o, s_dat_o, s_sel_o, s_we_o. Shared outputs are 0 in IDLE.
- Decode:
  - Slave i hits when (adr & MASK_i) == (BASE_i & MASK_i).
  - Multiple hits: lowest index wins.
  - s_cyc_o[i] = BUSY & cyc & hit_i; s_stb_o[i] = additionally stb.
- Termination:
  - m_ack_o/m_err_o/m_rty_o[g] = selected slave's ack/err/rty, combinational. All other masters see 0.
  - m_dat_o = s_dat_i of the selected slave, else 0.
- Unmapped address (no hit, stb=1):
  - No slave strobed.
  - Registered m_err_o pulse one cycle after stb is first seen, lasting exactly 1 cycle per strobe.
  - If the master keeps stb high after the err (next access), this repeats every 2 cycles.
- Timeout (TIMEOUT>0):
  - Counter increments each BUSY cycle with stb=1 and no ack/err/rty from the selected slave.
  - Counter clears on any termination, stb=0, or grant change.
  - When the count reaches TIMEOUT: 1-cycle m_err_o to the granted master, s_stb_o forced 0 that cycle, counter clears.
- Simultaneous ack and err from a slave are passed through unchanged. ack/err/rty are never asserted by the interconnect in the same cycle as a slave termination.
- MASTERS=1: arbitration is trivial, but the IDLE→BUSY latency is unchanged.

Test Plan:
- Single master M0 reads 0x1000_0004, slave1 BASE=0x1000_0000 MASK=0xF000_0000, ack in 2 cycles with dat=0xDEADBEEF → s_stb_o=0b0010, m_dat_o=0xDEADBEEF, m_ack_o=0b01 for 1 cycle, grant_o=0b01 until cyc drops.
- M0 and M1 request continuously with 1-beat cycles → grants alternate 01,10,01,10; idle cycle between each; M1 never starved.
- M1 holds cyc over 3 beats while M0 requests → grant_o stays 0b10 for all 3 acks; M0 granted after M1 drops cyc.
- Access to 0x5000_0000 with no slave mapped → all s_stb_o=0, m_err_o[g]=1 exactly one cycle after stb.
- TIMEOUT=8, slave never responds → m_err_o pulses at the 8th stb cycle, counter restarts, no ack.
- rst asserted in the cycle after grant while a slave stb is high → next edge: grant_o=0, s_stb_o=0, no termination to the master, pointer=0.

Source files
------------

// File: rtl/wb_shared_bus_rr.sv
// Wishbone B4 classic shared-bus interconnect: N masters share one bus to M
// slaves. Round-robin arbitration holds the grant for the whole cycle, slaves
// are decoded from base/mask pairs, and the interconnect raises its own err
// on unmapped addresses and on slaves that never terminate.
//
// state | meaning
// IDLE  | no grant; arbitrate among m_cyc_i requests from the rr pointer
// BUSY  | one master owns the bus until it drops cyc
module wb_shared_bus_rr #(
    parameter int MASTERS      = 2,
    parameter int SLAVES       = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8,
    parameter logic [SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = '0,
    parameter logic [SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = '0,
    parameter int TIMEOUT      = 255
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [MASTERS*ADDR_WIDTH-1:0]    m_adr_i,
    input  logic [MASTERS*DATA_WIDTH-1:0]    m_dat_i,
    input  logic [MASTERS*SELECT_WIDTH-1:0]  m_sel_i,
    input  logic [MASTERS-1:0]               m_we_i,
    input  logic [MASTERS-1:0]               m_stb_i,
    input  logic [MASTERS-1:0]               m_cyc_i,
    output logic [DATA_WIDTH-1:0]            m_dat_o,
    output logic [MASTERS-1:0]               m_ack_o,
    output logic [MASTERS-1:0]               m_err_o,
    output logic [MASTERS-1:0]               m_rty_o,
    output logic [ADDR_WIDTH-1:0]            s_adr_o,
    output logic [DATA_WIDTH-1:0]            s_dat_o,
    output logic [SELECT_WIDTH-1:0]          s_sel_o,
    output logic                             s_we_o,
    output logic [SLAVES-1:0]                s_cyc_o,
    output logic [SLAVES-1:0]                s_stb_o,
    input  logic [SLAVES*DATA_WIDTH-1:0]     s_dat_i,
    input  logic [SLAVES-1:0]                s_ack_i,
    input  logic [SLAVES-1:0]                s_err_i,
    input  logic [SLAVES-1:0]                s_rty_i,
    output logic [MASTERS-1:0]               grant_o
);

    localparam int MW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
    localparam int SW = (SLAVES > 1) ? $clog2(SLAVES) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [MASTERS-1:0] grant_q, grant_d;
    logic [MW-1:0]      gidx_q, gidx_d;
    logic [MW-1:0]      ptr_q, ptr_d;
    logic [TW-1:0]      tmo_q, tmo_d;
    logic               err_pend_q, err_pend_d;

    logic                    busy, cyc_g, stb_g, we_g;
    logic [ADDR_WIDTH-1:0]   adr_g;
    logic [DATA_WIDTH-1:0]   dat_g;
    logic [SELECT_WIDTH-1:0] sel_g;
    logic                    hit;
    logic [SW-1:0]           hidx;
    logic                    sl_ack, sl_err, sl_rty, sl_term, tmo_fire, ic_err;
    logic                    found;
    int                      idx;

    // Route the granted master onto the shared bus; everything is 0 when idle.
    always_comb begin
        busy  = (state_q == BUSY);
        cyc_g = busy & m_cyc_i[gidx_q];
        stb_g = busy & m_stb_i[gidx_q];
        we_g  = busy & m_we_i[gidx_q];
        adr_g = busy ? m_adr_i[gidx_q*ADDR_WIDTH +: ADDR_WIDTH] : '0;
        dat_g = busy ? m_dat_i[gidx_q*DATA_WIDTH +: DATA_WIDTH] : '0;
        sel_g = busy ? m_sel_i[gidx_q*SELECT_WIDTH +: SELECT_WIDTH] : '0;
    end

    // Address decode; scanning downward lets the lowest matching slave win.
    always_comb begin
        hit  = 1'b0;
        hidx = '0;
        for (int i = SLAVES - 1; i >= 0; i--) begin
            if ((adr_g & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                (SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH] & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                hit  = 1'b1;
                hidx = SW'(i);
            end
        end
        hit = hit & busy;
    end

    // Termination sources; the interconnect error never overlaps a slave termination.
    always_comb begin
        sl_ack   = hit & s_ack_i[hidx];
        sl_err   = hit & s_err_i[hidx];
        sl_rty   = hit & s_rty_i[hidx];
        sl_term  = sl_ack | sl_err | sl_rty;
        tmo_fire = (TIMEOUT > 0) && cyc_g && stb_g && hit && (tmo_q == TMO_LAST);
        ic_err   = (err_pend_q | tmo_fire) & ~sl_term;
    end

    // Per-slave cyc/stb; stb is withheld in the cycle a timeout fires.
    always_comb begin
        s_cyc_o = '0;
        s_stb_o = '0;
        for (int i = 0; i < SLAVES; i++) begin
            s_cyc_o[i] = cyc_g & hit & (hidx == SW'(i));
            s_stb_o[i] = s_cyc_o[i] & stb_g & ~tmo_fire;
        end
    end

    assign m_dat_o = hit ? s_dat_i[hidx*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign m_ack_o = grant_q & {MASTERS{sl_ack}};
    assign m_err_o = grant_q & {MASTERS{sl_err | ic_err}};
    assign m_rty_o = grant_q & {MASTERS{sl_rty}};
    assign s_adr_o = adr_g;
    assign s_dat_o = dat_g;
    assign s_sel_o = sel_g;
    assign s_we_o  = we_g;
    assign grant_o = grant_q;

    // Arbitration, grant release, unmapped-error and timeout bookkeeping.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        gidx_d     = gidx_q;
        ptr_d      = ptr_q;
        tmo_d      = '0;
        err_pend_d = 1'b0;
        found      = 1'b0;
        idx        = 0;
        case (state_q)
            IDLE: begin
                for (int k = 0; k < MASTERS; k++) begin
                    idx = (int'(ptr_q) + k) % MASTERS;
                    if (!found && m_cyc_i[idx]) begin
                        found  = 1'b1;
                        gidx_d = MW'(idx);
                    end
                end
                if (found) begin
                    state_d         = BUSY;
                    grant_d         = '0;
                    grant_d[gidx_d] = 1'b1;
                end
            end
            BUSY: begin
                if (!m_cyc_i[gidx_q]) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = (gidx_q == MW'(MASTERS - 1)) ? '0 : gidx_q + 1'b1;
                end else begin
                    err_pend_d = stb_g & ~hit & ~err_pend_q;
                    if ((TIMEOUT > 0) && stb_g && hit && !sl_term && !tmo_fire)
                        tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            gidx_q     <= '0;
            ptr_q      <= '0;
            tmo_q      <= '0;
            err_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            gidx_q     <= gidx_d;
            ptr_q      <= ptr_d;
            tmo_q      <= tmo_d;
            err_pend_q <= err_pend_d;
        end
    end

endmodule

// File: tb/tb_wb_shared_bus_rr.sv
// Directed bench for wb_shared_bus_rr: two masters, four slaves at
// 0x0/0x1/0x2/0x3 in the top nibble, TIMEOUT=8.
module tb_wb_shared_bus_rr;

    localparam int NM = 2;
    localparam int NS = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = 4;
    localparam logic [NS*AW-1:0] BASE = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [NS*AW-1:0] MASK = {4{32'hF000_0000}};
    // responder kind per slave: 0 ack, 1 err, 2 rty, 3 silent
    localparam int KIND [NS] = '{0, 0, 2, 3};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NM*AW-1:0] m_adr = '0;
    logic [NM*DW-1:0] m_dat = '0;
    logic [NM*SW-1:0] m_sel = '0;
    logic [NM-1:0]    m_we = '0, m_stb = '0, m_cyc = '0;
    logic [DW-1:0]    m_dat_o;
    logic [NM-1:0]    m_ack_o, m_err_o, m_rty_o, grant_o;
    logic [AW-1:0]    s_adr_o;
    logic [DW-1:0]    s_dat_o;
    logic [SW-1:0]    s_sel_o;
    logic             s_we_o;
    logic [NS-1:0]    s_cyc_o, s_stb_o;
    logic [NS*DW-1:0] s_dat = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h0000_AAAA};
    logic [NS-1:0]    s_ack = '0, s_err = '0, s_rty = '0;
    int               wcnt [NS] = '{default: 0};

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_shared_bus_rr #(
        .MASTERS(NM), .SLAVES(NS), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW),
        .SLAVE_BASE(BASE), .SLAVE_MASK(MASK), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
        .m_stb_i(m_stb), .m_cyc_i(m_cyc),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
        .grant_o(grant_o)
    );

    // Slave models: terminate two clocks after stb is first seen, one-cycle pulse.
    always @(posedge clk) begin
        for (int i = 0; i < NS; i++) begin
            if (s_stb_o[i] && !(s_ack[i] | s_err[i] | s_rty[i]) && KIND[i] != 3) begin
                if (wcnt[i] == 1) begin
                    wcnt[i]  <= 0;
                    s_ack[i] <= (KIND[i] == 0);
                    s_err[i] <= (KIND[i] == 1);
                    s_rty[i] <= (KIND[i] == 2);
                end else begin
                    wcnt[i] <= wcnt[i] + 1;
                end
            end else begin
                wcnt[i]  <= 0;
                s_ack[i] <= 1'b0;
                s_err[i] <= 1'b0;
                s_rty[i] <= 1'b0;
            end
        end
    end

    task automatic raise(input int m, input logic [AW-1:0] a, input logic w);
        m_adr[m*AW +: AW] = a;
        m_dat[m*DW +: DW] = {16'hCAFE, 16'(m)};
        m_sel[m*SW +: SW] = 4'hF;
        m_we[m]  = w;
        m_cyc[m] = 1'b1;
        m_stb[m] = 1'b1;
    endtask

    task automatic drop(input int m);
        m_cyc[m] = 1'b0;
        m_stb[m] = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        raise(0, 32'h1000_0000, 1'b0);
        repeat (3) @(negedge clk);
        n_checks++; if (grant_o !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b want 00", grant_o); end
        n_checks++; if (s_stb_o !== 4'b0000 || s_cyc_o !== 4'b0000) begin n_fail++; $display("FAIL reset_slave_strobes: stb %b cyc %b want 0", s_stb_o, s_cyc_o); end
        n_checks++; if ({m_ack_o, m_err_o, m_rty_o} !== 6'b0) begin n_fail++; $display("FAIL reset_term: ack %b err %b rty %b want 0", m_ack_o, m_err_o, m_rty_o); end
        n_checks++; if (m_dat_o !== 32'h0 || s_adr_o !== 32'h0) begin n_fail++; $display("FAIL reset_data: m_dat_o %h s_adr_o %h want 0", m_dat_o, s_adr_o); end
        drop(0);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_read;
        raise(0, 32'h1000_0004, 1'b0);
        @(negedge clk);
        n_checks++; if (grant_o !== 2'b01) begin n_fail++; $display("FAIL read_grant: got %b want 01", grant_o); end
        n_checks++; if (s_stb_o !== 4'b0010 || s_cyc_o !== 4'b0010) begin n_fail++; $display("FAIL read_decode: stb %b cyc %b want 0010", s_stb_o, s_cyc_o); end
        n_checks++; if (s_adr_o !== 32'h1000_0004 || s_we_o !== 1'b0) begin n_fail++; $display("FAIL read_mux: adr %h we %b want 10000004/0", s_adr_o, s_we_o); end
        n_checks++; if (m_ack_o !== 2'b00) begin n_fail++; $display("FAIL read_early_ack1: got %b want 00", m_ack_o); end
        @(negedge clk);
        n_checks++; if (m_ack_o !== 2'b00 || grant_o !== 2'b01) begin n_fail++; $display("FAIL read_wait: ack %b grant %b want 00/01", m_ack_o, grant_o); end
        @(negedge clk);
        n_checks++; if (m_ack_o !== 2'b01) begin n_fail++; $display("FAIL read_ack: got %b want 01", m_ack_o); end
        n_checks++; if (m_dat_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL read_data: got %h want deadbeef", m_dat_o); end
        drop(0);
        @(negedge clk);
        n_checks++; if (grant_o !== 2'b00 || m_ack_o !== 2'b00) begin n_fail++; $display("FAIL read_release: grant %b ack %b want 00/00", grant_o, m_ack_o); end
    endtask

    task automatic test_round_robin;
        logic [1:0] exp_g [4];
        int w;
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        raise(0, 32'h0000_0010, 1'b0);
        raise(1, 32'h0000_0020, 1'b0);
        for (int b = 0; b < 4; b++) begin
            w = 0;
            @(negedge clk);
            while (m_ack_o === 2'b00 && w < 20) begin @(negedge clk); w++; end
            n_checks++; if (m_ack_o === 2'b00) begin n_fail++; $display("FAIL rr_ack_wait beat %0d: no ack within 20 cycles", b); end
            n_checks++; if (grant_o !== exp_g[b]) begin n_fail++; $display("FAIL rr_grant beat %0d: got %b want %b", b, grant_o, exp_g[b]); end
            n_checks++; if (m_ack_o !== exp_g[b]) begin n_fail++; $display("FAIL rr_ack beat %0d: got %b want %b", b, m_ack_o, exp_g[b]); end
            for (int m = 0; m < NM; m++) if (grant_o[m]) drop(m);
            @(negedge clk);
            n_checks++; if (grant_o !== 2'b00) begin n_fail++; $display("FAIL rr_idle_gap beat %0d: got %b want 00", b, grant_o); end
            if (b < 3) begin
                raise(0, 32'h0000_0010, 1'b0);
                raise(1, 32'h0000_0020, 1'b0);
            end else begin
                drop(0);
                drop(1);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_hold_multi_beat;
        int w;
        raise(1, 32'h1000_0100, 1'b1);
        @(negedge clk);
        n_checks++; if (grant_o !== 2'b10) begin n_fail++; $display("FAIL hold_grant: got %b want 10", grant_o); end
        n_checks++; if (s_we_o !== 1'b1 || s_dat_o !== 32'hCAFE_0001 || s_sel_o !== 4'hF) begin n_fail++; $display("FAIL hold_write_mux: we %b dat %h sel %h want 1/cafe0001/f", s_we_o, s_dat_o, s_sel_o); end
        raise(0, 32'h0000_0040, 1'b0);
        for (int b = 0; b < 3; b++) begin
            w = 0;
            @(negedge clk);
            while (m_ack_o === 2'b00 && w < 20) begin @(negedge clk); w++; end
            n_checks++; if (grant_o !== 2'b10 || m_ack_o !== 2'b10) begin n_fail++; $display("FAIL hold_beat %0d: grant %b ack %b want 10/10", b, grant_o, m_ack_o); end
        end
        drop(1);
        @(negedge clk);
        n_checks++; if (grant_o !== 2'b00) begin n_fail++; $display("FAIL hold_gap: got %b want 00", grant_o); end
        @(negedge clk);
        n_checks++; if (grant_o !== 2'b01) begin n_fail++; $display("FAIL hold_next_grant: got %b want 01", grant_o); end
        w = 0;
        while (m_ack_o === 2'b00 && w < 20) begin @(negedge clk); w++; end
        n_checks++; if (m_ack_o !== 2'b01) begin n_fail++; $display("FAIL hold_m0_ack: got %b want 01", m_ack_o); end
        drop(0);
        @(negedge clk);
    endtask

    task automatic test_unmapped;
        raise(0, 32'h5000_0000, 1'b0);
        @(negedge clk);
        n_checks++; if (grant_o !== 2'b01) begin n_fail++; $display("FAIL unmap_grant: got %b want 01", grant_o); end
        n_checks++; if (s_stb_o !== 4'b0000 || s_cyc_o !== 4'b0000) begin n_fail++; $display("FAIL unmap_no_strobe: stb %b cyc %b want 0", s_stb_o, s_cyc_o); end
        n_checks++; if (m_err_o !== 2'b00) begin n_fail++; $display("FAIL unmap_err_early: got %b want 00", m_err_o); end
        @(negedge clk);
        n_checks++; if (m_err_o !== 2'b01) begin n_fail++; $display("FAIL unmap_err: got %b want 01", m_err_o); end
        @(negedge clk);
        n_checks++; if (m_err_o !== 2'b00) begin n_fail++; $display("FAIL unmap_err_width: got %b want 00", m_err_o); end
        @(negedge clk);
        n_checks++; if (m_err_o !== 2'b01) begin n_fail++; $display("FAIL unmap_err_repeat: got %b want 01", m_err_o); end
        drop(0);
        @(negedge clk);
        n_checks++; if (grant_o !== 2'b00 || m_err_o !== 2'b00) begin n_fail++; $display("FAIL unmap_release: grant %b err %b want 00/00", grant_o, m_err_o); end
    endtask

    task automatic test_timeout;
        logic [1:0] exp_e;
        logic [3:0] exp_s;
        raise(0, 32'h3000_0000, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            exp_e = (k == 8 || k == 16) ? 2'b01 : 2'b00;
            exp_s = (k == 8 || k == 16) ? 4'b0000 : 4'b1000;
            n_checks++; if (m_err_o !== exp_e) begin n_fail++; $display("FAIL tmo_err cycle %0d: got %b want %b", k, m_err_o, exp_e); end
            n_checks++; if (s_stb_o !== exp_s || m_ack_o !== 2'b00) begin n_fail++; $display("FAIL tmo_stb cycle %0d: stb %b ack %b want %b/00", k, s_stb_o, m_ack_o, exp_s); end
        end
        drop(0);
        @(negedge clk);
        n_checks++; if (grant_o !== 2'b00) begin n_fail++; $display("FAIL tmo_release: got %b want 00", grant_o); end
    endtask

    task automatic test_retry;
        raise(0, 32'h2000_0008, 1'b0);
        repeat (3) @(negedge clk);
        n_checks++; if (m_rty_o !== 2'b01 || m_ack_o !== 2'b00 || m_err_o !== 2'b00) begin n_fail++; $display("FAIL retry_pass: rty %b ack %b err %b want 01/00/00", m_rty_o, m_ack_o, m_err_o); end
        n_checks++; if (m_dat_o !== 32'h2222_2222) begin n_fail++; $display("FAIL retry_data: got %h want 22222222", m_dat_o); end
        drop(0);
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        raise(1, 32'h1000_0000, 1'b0);
        @(negedge clk);
        n_checks++; if (grant_o !== 2'b10 || s_stb_o !== 4'b0010) begin n_fail++; $display("FAIL rstmid_pre: grant %b stb %b want 10/0010", grant_o, s_stb_o); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (grant_o !== 2'b00 || s_stb_o !== 4'b0000) begin n_fail++; $display("FAIL rstmid_drop: grant %b stb %b want 00/0000", grant_o, s_stb_o); end
        n_checks++; if ({m_ack_o, m_err_o, m_rty_o} !== 6'b0) begin n_fail++; $display("FAIL rstmid_no_term: ack %b err %b rty %b want 0", m_ack_o, m_err_o, m_rty_o); end
        rst = 1'b0;
        raise(0, 32'h0000_0000, 1'b0);
        @(negedge clk);
        n_checks++; if (grant_o !== 2'b01) begin n_fail++; $display("FAIL rstmid_pointer: got %b want 01", grant_o); end
        n_checks++; if (m_ack_o !== 2'b00) begin n_fail++; $display("FAIL rstmid_stale_ack: got %b want 00", m_ack_o); end
        drop(0);
        drop(1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_hold_multi_beat();
        test_unmapped();
        test_timeout();
        test_retry();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
        $fatal(1);
    end

endmodule
